uart_tx_cfg: RTL and testbench

Parametrised UART transmitter, the successor to the fixed 8N1 transmitter. Serialises one parallel word per request onto `tx`, with configurable data width, stop-bit count and optional parity. Runs entirely in the system clock domain using a baud-rate enable tick, with no derived clock. It sits between a host/CSR or FIFO producer and the board-level TX pin.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_gen.sv | 31 +++
 rtl/uart_tx_cfg.sv | 150 +++++++++++++++
 tb/tb_uart_tx_cfg.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
// The PARITY encoding is kept even when UART_TX_PARITY_EN is undefined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  function automatic int uart_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud enable generator: one-cycle tick every DIV clocks while enabled.
// The counter is held at zero whenever en is low.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter (5..9 data bits, 1/2 stop bits).
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 1000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 newd,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 busy,
  output logic                 donetx
);

  localparam int DIV = uart_div(CLK_FREQ, BAUD_RATE);
  localparam int CW  = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_cfg: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_par
    $error("uart_tx_cfg: PARITY_ODD must be 0 or 1");
  end

  uart_tx_state_t       state, state_n;
  logic [DATA_BITS-1:0] data_q, data_n;
  logic [CW-1:0]        bit_cnt, bit_n, nxt;
  logic                 tx_n, busy_n, done_n;
  logic                 tick;

  uart_baud_gen #(
    .DIV(DIV)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .en  (busy),
    .tick(tick)
  );

`ifdef UART_TX_PARITY_EN
  logic par;
  assign par = (PARITY_ODD != 0) ? ~^data_q : ^data_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      data_q  <= '0;
      bit_cnt <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      donetx  <= 1'b0;
    end else begin
      state   <= state_n;
      data_q  <= data_n;
      bit_cnt <= bit_n;
      tx      <= tx_n;
      busy    <= busy_n;
      donetx  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    data_n  = data_q;
    bit_n   = bit_cnt;
    tx_n    = tx;
    busy_n  = busy;
    done_n  = 1'b0;
    nxt     = bit_cnt + 1'b1;
    unique case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (newd) begin
          data_n  = tx_data;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
          bit_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          bit_n   = '0;
          tx_n    = data_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = par;
`else
            state_n = STOP;
            tx_n    = 1'b1;
            bit_n   = '0;
`endif
          end else begin
            bit_n = nxt;
            tx_n  = data_q[nxt];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_n = STOP;
          tx_n    = 1'b1;
          bit_n   = '0;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (bit_cnt == LAST_STOP) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            bit_n   = '0;
          end else begin
            bit_n = nxt;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: an 8-bit/1-stop even and a 5-bit/2-stop odd instance.
// Line waveforms come from a frame model built from the framing rules.
module tb_uart_tx_cfg;

  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       newd_a, newd_b;
  logic [7:0] data_a;
  logic [4:0] data_b;
  logic       tx_a, busy_a, done_a;
  logic       tx_b, busy_b, done_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(
    .CLK_FREQ  (1000000),
    .BAUD_RATE (100000),
    .DATA_BITS (8),
    .STOP_BITS (1),
    .PARITY_ODD(0)
  ) dut_a (
    .clk    (clk),
    .rst    (rst),
    .newd   (newd_a),
    .tx_data(data_a),
    .tx     (tx_a),
    .busy   (busy_a),
    .donetx (done_a)
  );

  uart_tx_cfg #(
    .CLK_FREQ  (1000000),
    .BAUD_RATE (100000),
    .DATA_BITS (5),
    .STOP_BITS (2),
    .PARITY_ODD(1)
  ) dut_b (
    .clk    (clk),
    .rst    (rst),
    .newd   (newd_b),
    .tx_data(data_b),
    .tx     (tx_b),
    .busy   (busy_b),
    .donetx (done_b)
  );

  typedef struct {
    int         w;
    logic [8:0] d;
    int         exp_cycles;
    int         exp_par;
    bit         glitch;
  } vec_t;

  vec_t tbl[$];

  function automatic int dbits(input int w);
    return (w != 0) ? 5 : 8;
  endfunction

  function automatic int sbits(input int w);
    return (w != 0) ? 2 : 1;
  endfunction

  function automatic int model_par(input int w, input logic [8:0] d);
    logic [8:0] m;
    m = d & ((9'h1 << dbits(w)) - 9'h1);
    return ($countones(m) % 2) ^ ((w != 0) ? 1 : 0);
  endfunction

  // Frame as a list of line bits: start, data LSB first, [parity], stops.
  function automatic logic mbit(input int w, input logic [8:0] d, input int k);
    int db;
    db = dbits(w);
    if (k == 0) return 1'b0;
    if (k <= db) return d[k-1];
    if (P == 1 && k == db + 1) return model_par(w, d) != 0;
    return 1'b1;
  endfunction

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int w, input logic n, input logic [8:0] d);
    if (w == 0) begin
      newd_a = n;
      data_a = d[7:0];
    end else begin
      newd_b = n;
      data_b = d[4:0];
    end
  endtask

  task automatic run_frame(input int w, input logic [8:0] d, input int exp_cycles,
                           input int exp_par, input bit launch, input bit hold,
                           input bit glitch, input logic [8:0] next_d);
    int   n, len, done_at, busy_n, par_seen, anom;
    int   bad[16];
    logic t, b, dn;
    n        = 1 + dbits(w) + P + sbits(w);
    len      = n * DIV;
    done_at  = -1;
    busy_n   = 0;
    par_seen = -1;
    foreach (bad[i]) bad[i] = 0;
    if (launch) drive(w, 1'b1, d);
    for (int c = 0; c <= len; c++) begin
      @(negedge clk);
      t  = (w != 0) ? tx_b : tx_a;
      b  = (w != 0) ? busy_b : busy_a;
      dn = (w != 0) ? done_b : done_a;
      if (c < len && (t !== mbit(w, d, c / DIV) || b !== 1'b1 || dn !== 1'b0))
        bad[c/DIV]++;
      if (dn === 1'b1 && done_at < 0) done_at = c;
      if (b === 1'b1) busy_n++;
      if (c == (dbits(w) + 1) * DIV + DIV / 2) par_seen = int'(t);
      if (c == 0) drive(w, hold, hold ? next_d : 9'($urandom));
      else if (glitch && c == 4 * DIV + 5) drive(w, 1'b1, 9'h1FF);
      else if (glitch && c == 4 * DIV + 6) drive(w, 1'b0, 9'h1FF);
    end
    for (int k = 0; k < n; k++)
      chk(bad[k] == 0, $sformatf("w%0d d=%h line bit %0d bad cycles", w, d, k), bad[k], 0);
    chk(done_at == exp_cycles, $sformatf("w%0d d=%h donetx cycle", w, d), done_at, exp_cycles);
    chk(busy_n == exp_cycles, $sformatf("w%0d d=%h busy cycles", w, d), busy_n, exp_cycles);
    if (P == 1)
      chk(par_seen == exp_par, $sformatf("w%0d d=%h parity bit", w, d), par_seen, exp_par);
    if (!hold) begin
      anom = 0;
      for (int c = 0; c < 3 * DIV; c++) begin
        @(negedge clk);
        t  = (w != 0) ? tx_b : tx_a;
        b  = (w != 0) ? busy_b : busy_a;
        dn = (w != 0) ? done_b : done_a;
        if (b !== 1'b0 || t !== 1'b1 || dn !== 1'b0) anom++;
      end
      chk(anom == 0, $sformatf("w%0d d=%h idle after frame", w, d), anom, 0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ca, cb, anom;
    logic [8:0] r;
    ca = (P != 0) ? 110 : 100;
    cb = (P != 0) ? 90 : 80;
    tbl.push_back('{0, 9'h0A5, ca, 0, 1'b1});
    tbl.push_back('{0, 9'h007, ca, 1, 1'b0});
    tbl.push_back('{0, 9'h000, ca, 0, 1'b0});
    tbl.push_back('{0, 9'h0FF, ca, 0, 1'b0});
    tbl.push_back('{0, 9'h001, ca, 1, 1'b0});
    tbl.push_back('{1, 9'h013, cb, 0, 1'b0});
    tbl.push_back('{1, 9'h000, cb, 1, 1'b0});
    for (int i = 0; i < 6; i++) begin
      r = 9'($urandom_range(0, 255));
      tbl.push_back('{0, r, (1 + 8 + P + 1) * DIV, model_par(0, r), 1'b0});
    end
    for (int i = 0; i < 4; i++) begin
      r = 9'($urandom_range(0, 31));
      tbl.push_back('{1, r, (1 + 5 + P + 2) * DIV, model_par(1, r), i == 0});
    end

    rst    = 1'b1;
    newd_a = 1'b0;
    newd_b = 1'b0;
    data_a = '0;
    data_b = '0;
    repeat (2) @(negedge clk);
    chk(tx_a === 1'b1, "reset tx a", int'(tx_a), 1);
    chk(busy_a === 1'b0, "reset busy a", int'(busy_a), 0);
    chk(done_a === 1'b0, "reset donetx a", int'(done_a), 0);
    chk(tx_b === 1'b1, "reset tx b", int'(tx_b), 1);
    chk(busy_b === 1'b0, "reset busy b", int'(busy_b), 0);
    chk(done_b === 1'b0, "reset donetx b", int'(done_b), 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i])
      run_frame(tbl[i].w, tbl[i].d, tbl[i].exp_cycles, tbl[i].exp_par,
                1'b1, 1'b0, tbl[i].glitch, 9'h0);

    // Back-to-back: newd held through donetx, word swapped after accept.
    run_frame(0, 9'h03C, ca, 0, 1'b1, 1'b1, 1'b0, 9'h0C3);
    run_frame(0, 9'h0C3, ca, 0, 1'b0, 1'b0, 1'b0, 9'h0);

    // Reset during data bit 3 of 0x96 (bit 3 is 0, so tx is low).
    drive(0, 1'b1, 9'h096);
    @(negedge clk);
    drive(0, 1'b0, 9'h000);
    repeat (4 * DIV + 3) @(negedge clk);
    chk(tx_a === 1'b0, "pre-reset tx low", int'(tx_a), 0);
    rst = 1'b1;
    #1;
    chk({tx_a, busy_a} === 2'b10, "async reset tx/busy", int'({tx_a, busy_a}), 2);
    anom = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_a !== 1'b0 || tx_a !== 1'b1) anom++;
    end
    chk(anom == 0, "reset hold no donetx", anom, 0);
    rst = 1'b0;
    @(negedge clk);
    run_frame(0, 9'h055, ca, 0, 1'b1, 1'b0, 1'b0, 9'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
